// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state encoding, default widths and the
// architectural constants used for divide-by-zero and signed overflow.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned CNT_W_DEFAULT = 6;

    // RV32M funct3 encodings
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (execute stage, feeds the register
// file write port). Operands are converted to magnitudes at start, 32
// shift-add / restoring-divide iterations run in CALC, and FIXUP applies the
// sign and selects the upper/lower half. done/wb_we pulse one cycle after the
// DONE state; result/rd_out hold until the next completed op.
//
// Ports:
//   CLK     - clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - request strobe, honoured only in IDLE/DONE
//   kill    - abort the in-flight op (wins over start)
//   funct3  - RV32M op select
//   op_a    - rs1 value (multiplicand / dividend)
//   op_b    - rs2 value (multiplier / divisor)
//   rd_in   - destination register
//   busy    - op in flight
//   done    - one-cycle completion pulse
//   result  - op result
//   rd_out  - destination register of result
//   wb_we   - register-file write enable (done and rd_out != 0)
//
// Build option: define MULDIV_EARLY_OUT_EN to let divide-by-zero, signed
// overflow and zero multiply operands skip CALC/FIXUP and finish directly.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wb_we
);

    localparam int unsigned      AW        = 2 * XLEN;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    acc;     // mul: {hi, multiplier/lo}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]  mcand;   // multiplicand or divisor magnitude
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic             neg_q;   // negate product / quotient
    logic             rneg_q;  // remainder takes dividend sign
    logic             div0_q;
    logic [XLEN-1:0]  res_q;   // staged result, published on leaving DONE

    // Operand sign extraction and magnitude conversion at start
    logic            a_neg_c, b_neg_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c;

    assign a_neg_c = op_a_signed(funct3) & op_a[XLEN-1];
    assign b_neg_c = op_b_signed(funct3) & op_b[XLEN-1];
    assign a_mag_c = a_neg_c ? XLEN'(0) - op_a : op_a;
    assign b_mag_c = b_neg_c ? XLEN'(0) - op_b : op_b;

    // One shift-add multiply step and one restoring divide step
    logic [XLEN:0]   mul_sum_c, rem_sh_c, div_diff_c;
    logic            q_bit_c;
    logic [XLEN-1:0] rem_nxt_c;

    assign mul_sum_c  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    assign rem_sh_c   = {acc[AW-1:XLEN], acc[XLEN-1]};
    assign div_diff_c = rem_sh_c - {1'b0, mcand};
    assign q_bit_c    = ~div_diff_c[XLEN];
    assign rem_nxt_c  = q_bit_c ? div_diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];

    // Sign correction and half/quotient/remainder select
    logic [AW-1:0]   prod_c;
    logic [XLEN-1:0] quot_c, rem_c, fix_c;

    assign prod_c = neg_q  ? AW'(0) - acc : acc;
    assign quot_c = neg_q  ? XLEN'(0) - acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_c  = rneg_q ? XLEN'(0) - acc[AW-1:XLEN] : acc[AW-1:XLEN];

    always_comb begin
        fix_c = prod_c[XLEN-1:0];
        case (f3_q)
            MD_MUL:                       fix_c = prod_c[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_c = prod_c[AW-1:XLEN];
            // a zero divisor yields an all-ones magnitude; the sign must not touch it
            MD_DIV, MD_DIVU:              fix_c = div0_q ? DIV0_QUOT : quot_c;
            default:                      fix_c = rem_c;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Special cases resolvable without iterating
    logic            eo_hit_c;
    logic [XLEN-1:0] eo_res_c;

    always_comb begin
        eo_hit_c = 1'b0;
        eo_res_c = '0;
        if (funct3[2]) begin
            if (op_b == '0) begin
                eo_hit_c = 1'b1;
                eo_res_c = funct3[1] ? op_a : DIV0_QUOT;
            end else if (!funct3[0] && (op_a == INT_MIN) && (op_b == '1)) begin
                eo_hit_c = 1'b1;
                eo_res_c = funct3[1] ? '0 : INT_MIN;
            end
        end else if ((op_a == '0) || (op_b == '0)) begin
            eo_hit_c = 1'b1;
        end
    end
`endif

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            f3_q   <= MD_MUL;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
            res_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wb_we  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            if (kill) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (state == ST_DONE) begin
                            done   <= 1'b1;
                            wb_we  <= (rd_q != 5'd0);
                            result <= res_q;
                            rd_out <= rd_q;
                        end
                        state <= ST_IDLE;
                        if (start) begin
                            f3_q   <= funct3;
                            rd_q   <= rd_in;
                            cnt    <= '0;
                            neg_q  <= a_neg_c ^ b_neg_c;
                            rneg_q <= a_neg_c;
                            div0_q <= funct3[2] & (op_b == '0);
                            if (funct3[2]) begin
                                acc   <= {{XLEN{1'b0}}, a_mag_c};
                                mcand <= b_mag_c;
                            end else begin
                                acc   <= {{XLEN{1'b0}}, b_mag_c};
                                mcand <= a_mag_c;
                            end
                            state <= ST_CALC;
                            busy  <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                            if (eo_hit_c) begin
                                res_q <= eo_res_c;
                                state <= ST_DONE;
                                busy  <= 1'b0;
                            end
`endif
                        end
                    end
                    ST_CALC: begin
                        cnt <= cnt + CNT_W'(1);
                        if (f3_q[2]) begin
                            acc <= {rem_nxt_c, acc[XLEN-2:0], q_bit_c};
                        end else begin
                            acc <= {mul_sum_c, acc[XLEN-1:1]};
                        end
                        if (cnt == LAST_ITER) begin
                            state <= ST_FIXUP;
                        end
                    end
                    ST_FIXUP: begin
                        res_q <= fix_c;
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a transaction-level reference model
// (plain 64-bit arithmetic plus a completion countdown) is compared against
// every output on every cycle, and directed ops carry hand-computed results.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, wb_we;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_total = 0;
    int n_pass  = 0;

    muldiv_unit dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .wb_we  (wb_we)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Architectural RV32M result
    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin t = 64'(ua * ub);              return t[31:0];  end
            3'd1: begin t = 64'(sa * sb);              return t[63:32]; end
            3'd2: begin t = 64'(sa * longint'(ub));    return t[63:32]; end
            3'd3: begin t = 64'(ua * ub);              return t[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb; t = 64'(q); return t[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                t = 64'(ua / ub); return t[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb; t = 64'(q); return t[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                t = 64'(ua % ub); return t[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 32'd0) || (b == 32'd0);
    endfunction

    // Edges from the accepting edge until done is visible
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (is_special(f, a, b)) return 1;
`endif
        return 34;
    endfunction

    // Reference model: m_left counts edges until the pending op's done pulse
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res = 32'd0, p_res = 32'd0;
    logic [4:0]  m_rd = 5'd0, p_rd = 5'd0;
    bit          m_idle_before;

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = 32'd0;
            m_rd   = 5'd0;
        end else begin
            m_idle_before = (m_left <= 1);
            m_done = 1'b0;
            if (kill) begin
                m_left = 0;
            end else begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        m_res  = p_res;
                        m_rd   = p_rd;
                    end
                end
                if (start && m_idle_before) begin
                    p_res  = model_res(funct3, op_a, op_b);
                    p_rd   = rd_in;
                    m_left = exp_lat(funct3, op_a, op_b);
                end
            end
        end
        #1;
        chk("busy",   32'(busy),   32'(m_left >= 2));
        chk("done",   32'(done),   32'(m_done));
        chk("wb_we",  32'(wb_we),  32'(m_done && m_rd != 5'd0));
        chk("result", result,      m_res);
        chk("rd_out", 32'(rd_out), 32'(m_rd));
    end

    // Drive one start cycle, then scramble inputs to prove they were captured
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge CLK);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(negedge CLK);
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp, input logic [4:0] rd, input int lat);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge CLK);
            #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, "_result"}, result, exp);
            chk({name, "_rd_out"}, 32'(rd_out), 32'(rd));
            chk({name, "_wb_we"},  32'(wb_we), 32'(rd != 5'd0));
            if (lat >= 0) chk({name, "_latency"}, 32'(n), 32'(lat));
        end
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        chk({name, "_model"}, model_res(f, a, b), exp);
        issue(f, a, b, rd);
        wait_done(name, exp, rd, exp_lat(f, a, b));
    endtask

    initial begin
        bit dropped;
        start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
        reset = 1'b0;
        #2;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_wb_we",  32'(wb_we),  32'd0);
        chk("rst_result", result,      32'd0);
        chk("rst_rd_out", 32'(rd_out), 32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;

        run("mul",        3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run("mulhu",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE);
        run("mulh",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000);
        run("mulhsu",     3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF);
        run("div",        3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD);
        run("rem",        3'd6, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFF);
        run("divu",       3'd5, 32'd100,        32'd7,         5'd6,  32'd14);
        run("remu",       3'd7, 32'd100,        32'd7,         5'd6,  32'd2);
        run("divu_by0",   3'd5, 32'h1234,       32'd0,         5'd8,  32'hFFFF_FFFF);
        run("remu_by0",   3'd7, 32'h1234,       32'd0,         5'd8,  32'h1234);
        run("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000);
        run("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0);
        run("div_neg_by0",3'd4, 32'hFFFF_FFF9,  32'd0,         5'd10, 32'hFFFF_FFFF);
        run("rem_neg_by0",3'd6, 32'hFFFF_FFF9,  32'd0,         5'd10, 32'hFFFF_FFF9);
        run("mul_zero",   3'd0, 32'd0,          32'd5,         5'd11, 32'd0);
        run("rd0_divu",   3'd5, 32'd100,        32'd7,         5'd0,  32'd14);

        // start while busy is ignored
        issue(3'd5, 32'd100, 32'd7, 5'd3);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd12;
        @(negedge CLK);
        start = 1'b0;
        wait_done("start_busy", 32'd14, 5'd3, -1);

        // kill at cycle 10 (with a simultaneous start, which must be dropped)
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        kill = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd13;
        @(posedge CLK);
        #1;
        chk("kill_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        kill = 1'b0; start = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        chk("kill_result", result,      32'd14);
        chk("kill_rd_out", 32'(rd_out), 32'd3);

        // asynchronous reset at cycle 15 of a DIV
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
        repeat (14) @(posedge CLK);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_busy",   32'(busy),   32'd0);
        chk("midrst_done",   32'(done),   32'd0);
        chk("midrst_result", result,      32'd0);
        chk("midrst_rd_out", 32'(rd_out), 32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        repeat (40) @(posedge CLK);

        // back-to-back: second start accepted while the first op is in DONE
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        dropped = 0;
        for (int i = 0; i < 60 && !dropped; i++) begin
            @(posedge CLK);
            #1;
            if (busy === 1'b0) dropped = 1;
        end
        chk("b2b_busy_drop", 32'(dropped), 32'd1);
        issue(3'd5, 32'd100, 32'd7, 5'd6);
        chk("b2b_first_done",   32'(done), 32'd1);
        chk("b2b_first_result", result,    32'hFFFF_FFEB);
        chk("b2b_second_busy",  32'(busy), 32'd1);
        wait_done("b2b_second", 32'd14, 5'd6, 34);

        repeat (3) @(posedge CLK);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
